// File: rtl/serial_bus_arbiter_if.sv
// Handshake and select signals between the two serial-bus masters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface serial_bus_arbiter_if #(
  parameter int SLAVE_LEN = 2
);
  logic                      m1_request;
  logic                      m2_request;
  logic                      m1_slave_bit;
  logic                      m2_slave_bit;
  logic                      m1_trans_done;
  logic                      m2_trans_done;
  logic                      m1_grant;
  logic                      m2_grant;
  logic                      arbitor_busy;
  logic                      bus_busy;
  logic                      master_sel;
  logic [2**SLAVE_LEN-1:0]   slave_sel;
  logic                      timeout;

  modport master (
    output m1_request, m2_request, m1_slave_bit, m2_slave_bit,
           m1_trans_done, m2_trans_done,
    input  m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel,
           slave_sel, timeout
  );

  modport slave (
    input  m1_request, m2_request, m1_slave_bit, m2_slave_bit,
           m1_trans_done, m2_trans_done,
    output m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel,
           slave_sel, timeout
  );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Two-master round-robin arbiter: grants the bus, shifts in the serial slave address,
// holds the connection until trans_done or timeout, then releases for one cycle.
module serial_bus_arbiter #(
  parameter int SLAVE_LEN   = 2,
  parameter int TIMEOUT     = 1023,
  parameter int TIMEOUT_LEN = 10
) (
  input logic                 clk,
  input logic                 reset,
  serial_bus_arbiter_if.slave bus
);
  localparam int NUM_SLAVES  = 2**SLAVE_LEN;
  localparam int BIT_CNT_LEN = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, CONNECT, RELEASE} state_t;

  state_t                  state_reg;
  logic                    m1_grant_reg;
  logic                    m2_grant_reg;
  logic                    arbitor_busy_reg;
  logic                    bus_busy_reg;
  logic                    master_sel_reg;
  logic [NUM_SLAVES-1:0]   slave_sel_reg;
  logic                    timeout_reg;
  logic                    last_winner_reg;
  logic [BIT_CNT_LEN-1:0]  bit_cnt_reg;
  logic [SLAVE_LEN-1:0]    shift_reg;
  logic [TIMEOUT_LEN-1:0]  timeout_cnt_reg;

  logic                    sel_request;
  logic                    sel_bit;
  logic                    sel_done;
  logic                    any_request;
  logic                    arb_pick;
  logic                    last_bit;
  logic                    timeout_hit;
  logic [SLAVE_LEN-1:0]    shift_next;
  logic [NUM_SLAVES-1:0]   decode_next;

  assign sel_request = master_sel_reg ? bus.m2_request    : bus.m1_request;
  assign sel_bit     = master_sel_reg ? bus.m2_slave_bit  : bus.m1_slave_bit;
  assign sel_done    = master_sel_reg ? bus.m2_trans_done : bus.m1_trans_done;
  assign any_request = bus.m1_request | bus.m2_request;
  // On a tie the master that did not win last time gets the bus.
  assign arb_pick    = (bus.m1_request && bus.m2_request) ? ~last_winner_reg : bus.m2_request;
  assign last_bit    = (bit_cnt_reg == BIT_CNT_LEN'(SLAVE_LEN - 1));
  assign timeout_hit = (timeout_cnt_reg == TIMEOUT_LEN'(TIMEOUT - 1));
  assign shift_next  = SLAVE_LEN'({shift_reg, sel_bit});

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign decode_next[gi] = (shift_next == SLAVE_LEN'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      m1_grant_reg     <= 1'b0;
      m2_grant_reg     <= 1'b0;
      arbitor_busy_reg <= 1'b0;
      bus_busy_reg     <= 1'b0;
      master_sel_reg   <= 1'b0;
      slave_sel_reg    <= '0;
      timeout_reg      <= 1'b0;
      last_winner_reg  <= 1'b1;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      timeout_cnt_reg  <= '0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_request) begin
            master_sel_reg   <= arb_pick;
            m1_grant_reg     <= ~arb_pick;
            m2_grant_reg     <= arb_pick;
            arbitor_busy_reg <= 1'b1;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            state_reg        <= ADDR;
          end
        end
        ADDR: begin
          // A dropped request aborts before any slave is enabled.
          if (!sel_request) begin
            m1_grant_reg <= 1'b0;
            m2_grant_reg <= 1'b0;
            state_reg    <= RELEASE;
          end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_LEN'(1);
            if (last_bit) begin
              slave_sel_reg   <= decode_next;
              bus_busy_reg    <= 1'b1;
              timeout_cnt_reg <= '0;
              state_reg       <= CONNECT;
            end
          end
        end
        CONNECT: begin
          if (sel_done || timeout_hit) begin
            m1_grant_reg  <= 1'b0;
            m2_grant_reg  <= 1'b0;
            bus_busy_reg  <= 1'b0;
            slave_sel_reg <= '0;
            timeout_reg   <= ~sel_done;
            state_reg     <= RELEASE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TIMEOUT_LEN'(1);
          end
        end
        RELEASE: begin
          last_winner_reg  <= master_sel_reg;
          arbitor_busy_reg <= 1'b0;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.m1_grant     = m1_grant_reg;
  assign bus.m2_grant     = m2_grant_reg;
  assign bus.arbitor_busy = arbitor_busy_reg;
  assign bus.bus_busy     = bus_busy_reg;
  assign bus.master_sel   = master_sel_reg;
  assign bus.slave_sel    = slave_sel_reg;
  assign bus.timeout      = timeout_reg;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: cycle-by-cycle output snapshots are queued
// when stimulus is driven and compared after the clock edge that produces them.
module tb_serial_bus_arbiter;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_bus_arbiter_if #(.SLAVE_LEN(2)) bus ();

  serial_bus_arbiter #(
    .SLAVE_LEN(2),
    .TIMEOUT(8),
    .TIMEOUT_LEN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot order: m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel, slave_sel[3:0], timeout
  function automatic logic [9:0] snap();
    return {bus.m1_grant, bus.m2_grant, bus.arbitor_busy, bus.bus_busy,
            bus.master_sel, bus.slave_sel, bus.timeout};
  endfunction

  function automatic logic [9:0] sv(input logic g1, input logic g2, input logic ab,
                                    input logic bb, input logic ms, input logic [3:0] ss,
                                    input logic to);
    return {g1, g2, ab, bb, ms, ss, to};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] exp);
    sb_item_t it;
    sb_q.push_back('{tag: tag, exp: exp});
    @(posedge clk);
    #1;
    it = sb_q.pop_front();
    check(it.tag, snap(), it.exp);
  endtask

  // The other master's line carries the opposite bit so a wrong mux is visible.
  task automatic drive_bit(input logic m, input logic b);
    if (m == 1'b0) begin
      bus.m1_slave_bit = b;
      bus.m2_slave_bit = ~b;
    end else begin
      bus.m2_slave_bit = b;
      bus.m1_slave_bit = ~b;
    end
  endtask

  task automatic connect(input logic m, input logic [1:0] slv, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << slv;
    step({tag, "_grant"}, sv(~m, m, 1'b1, 1'b0, m, 4'b0, 1'b0));
    drive_bit(m, slv[1]);
    step({tag, "_addr"}, sv(~m, m, 1'b1, 1'b0, m, 4'b0, 1'b0));
    drive_bit(m, slv[0]);
    step({tag, "_conn"}, sv(~m, m, 1'b1, 1'b1, m, oh, 1'b0));
  endtask

  task automatic finish_conn(input logic m, input logic drop, input string tag);
    if (m == 1'b0) bus.m1_trans_done = 1'b1;
    else           bus.m2_trans_done = 1'b1;
    step({tag, "_release"}, sv(1'b0, 1'b0, 1'b1, 1'b0, m, 4'b0, 1'b0));
    bus.m1_trans_done = 1'b0;
    bus.m2_trans_done = 1'b0;
    if (drop) begin
      bus.m1_request = 1'b0;
      bus.m2_request = 1'b0;
    end
    step({tag, "_idle"}, sv(1'b0, 1'b0, 1'b0, 1'b0, m, 4'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b0;
    bus.m1_request    = 1'b0;
    bus.m2_request    = 1'b0;
    bus.m1_slave_bit  = 1'b0;
    bus.m2_slave_bit  = 1'b0;
    bus.m1_trans_done = 1'b0;
    bus.m2_trans_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_state", snap(), 10'b0);
    reset = 1'b1;

    // Single master, address bits 1,0 -> slave 2
    bus.m1_request = 1'b1;
    connect(1'b0, 2'b10, "single");
    step("single_hold", sv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0));
    finish_conn(1'b0, 1'b1, "single");
    step("single_quiet", sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0));

    // Tie held from reset: m1, m2, m1 alternate with back-to-back regrants
    reset = 1'b0;
    bus.m1_request = 1'b1;
    bus.m2_request = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    connect(1'b0, 2'b01, "rr1");
    finish_conn(1'b0, 1'b0, "rr1");
    connect(1'b1, 2'b11, "rr2");
    bus.m1_trans_done = 1'b1;
    step("wrong_done", sv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0));
    bus.m1_trans_done = 1'b0;
    step("wrong_done_after", sv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0));
    finish_conn(1'b1, 1'b0, "rr2");
    connect(1'b0, 2'b00, "rr3");
    finish_conn(1'b0, 1'b1, "rr3");

    // Timeout with TIMEOUT=8: pulse after edge C+8, together with bus_busy falling
    bus.m1_request = 1'b1;
    connect(1'b0, 2'b10, "to");
    for (int k = 1; k < 8; k++)
      step("to_wait", sv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0));
    step("to_fire", sv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b1));
    bus.m1_request = 1'b0;
    step("to_one_cycle", sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0));

    // trans_done on the timeout boundary suppresses the pulse
    bus.m1_request = 1'b1;
    connect(1'b0, 2'b11, "tie");
    for (int k = 1; k < 8; k++)
      step("tie_wait", sv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0));
    bus.m1_trans_done = 1'b1;
    step("tie_done_wins", sv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0));
    bus.m1_trans_done = 1'b0;
    bus.m1_request    = 1'b0;
    step("tie_idle", sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0));

    // Abort: m2 drops its request after the first address bit
    bus.m2_request = 1'b1;
    step("abort_grant", sv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0, 1'b0));
    drive_bit(1'b1, 1'b1);
    step("abort_addr", sv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0, 1'b0));
    bus.m2_request = 1'b0;
    step("abort_release", sv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0, 1'b0));
    step("abort_idle", sv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0));

    // m1 wins last, then m2 takes the tie and is reset mid-CONNECT
    bus.m1_request = 1'b1;
    connect(1'b0, 2'b01, "pre");
    finish_conn(1'b0, 1'b1, "pre");
    bus.m1_request = 1'b1;
    bus.m2_request = 1'b1;
    connect(1'b1, 2'b10, "mid");
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", snap(), 10'b0);
    @(posedge clk); #1;
    check("async_reset_held", snap(), 10'b0);
    reset = 1'b1;
    connect(1'b0, 2'b11, "post");
    finish_conn(1'b0, 1'b1, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
